// File: rtl/mult_seq_4bits_pkg.sv
// Shared controller definitions for adder-sharing sequential blocks:
// FSM state encodings, step count and the add-and-shift step helper.
package mult_seq_4bits_pkg;

    // FSM state encodings, reused by future adder-sharing controllers.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Number of add-and-shift steps for a 4-bit multiplier.
    localparam int unsigned N_PASSOS = 4;

    // Counter value on which the final step is taken.
    localparam logic [1:0] CNT_ULTIMO = 2'(N_PASSOS - 1);

    // One shift-and-add step on {Acc,Q}.  When the multiplier LSB is set,
    // the adder sum is taken and its carry becomes the new Acc MSB so it
    // is never lost; otherwise the accumulator is shifted in with a zero.
    function automatic logic [7:0] passo_shift(
        input logic       cout,
        input logic [3:0] soma,
        input logic [3:0] acc,
        input logic [3:0] q
    );
        logic [7:0] res;
        if (q[0]) begin
            res = {cout, soma, q[3:1]};
        end else begin
            res = {1'b0, acc, q[3:1]};
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_seq_4bits_somador.sv
// Somador4Bits: combinational 4-bit ripple-carry adder datapath.
module Somador4Bits (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [4:0] carry_s;

    // Ripple the carry through four full-adder cells.
    always_comb begin
        carry_s    = 5'b0_0000;
        S          = 4'b0000;
        carry_s[0] = Cin;
        for (int i = 0; i < 4; i++) begin
            S[i]         = A[i] ^ B[i] ^ carry_s[i];
            carry_s[i+1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
        end
        Cout = carry_s[4];
    end

endmodule

// File: rtl/mult_seq_4bits.sv
// mult_seq_4bits: sequential 4x4 unsigned shift-and-add multiplier.
// One add-and-shift step per clock through a single Somador4Bits, with a
// start/busy/done handshake. P holds the last completed product.
module mult_seq_4bits
    import mult_seq_4bits_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P,
    output logic       busy,
    output logic       done
);

    logic [1:0] estado_q, estado_d;
    logic [3:0] m_q, m_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] q_q, q_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] p_q, p_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] soma_s;
    logic       cout_s;
    logic [7:0] passo_s;

    Somador4Bits u_somador (
        .A    (acc_q),
        .B    (m_q),
        .Cin  (1'b0),
        .S    (soma_s),
        .Cout (cout_s)
    );

    // Post-step value of {Acc,Q} for the current cycle.
    always_comb begin
        passo_s = passo_shift(cout_s, soma_s, acc_q, q_q);
    end

    // Next-state logic: operand load, step sequencing and result write.
    always_comb begin
        estado_d = estado_q;
        m_d      = m_q;
        acc_d    = acc_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        case (estado_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    estado_d = ST_CALC;
                    m_d      = A;
                    q_d      = B;
                    acc_d    = 4'b0000;
                    cnt_d    = 2'b00;
                end else begin
                    estado_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                // start is deliberately ignored here: operands stay put
                {acc_d, q_d} = passo_s;
                if (cnt_q == CNT_ULTIMO) begin
                    estado_d = ST_DONE;
                    p_d      = passo_s;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: begin
                // unused encoding: fall back to IDLE without producing a result
                estado_d = ST_IDLE;
                cnt_d    = 2'b00;
            end
        endcase
        busy_d = (estado_d == ST_CALC);
        done_d = (estado_d == ST_DONE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= ST_IDLE;
            m_q      <= 4'b0000;
            acc_q    <= 4'b0000;
            q_q      <= 4'b0000;
            cnt_q    <= 2'b00;
            p_q      <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign P    = p_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_mult_seq_4bits.sv
// Scoreboard testbench for mult_seq_4bits.  The stimulus side decides from
// the handshake timing rules whether a start is accepted and queues A*B
// with the cycle its done is due; the monitor checks outputs every cycle.
module tb_mult_seq_4bits;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A_i;
    logic [3:0] B_i;
    logic [7:0] P;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] prod;
        int         due;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    int         cyc;
    int         last_acc;
    int         total;
    int         bad;
    logic [7:0] hold_p;
    logic       prev_done;
    logic       exp_busy;

    mult_seq_4bits dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A_i),
        .B     (B_i),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // edge counter: at a negedge, cyc is the number of the last rising edge
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", nm, got, req, cyc);
        end
    endtask

    // One cycle of stimulus for the next rising edge; an operation is
    // accepted when at least 5 edges have passed since the previous one,
    // and its done is visible 4 edges after acceptance.
    task automatic drive(input logic s, input logic [3:0] a, input logic [3:0] b);
        exp_t item;
        @(negedge clk);
        #1;
        start = s;
        A_i   = a;
        B_i   = b;
        if (s && (cyc + 1 - last_acc >= 5)) begin
            item.prod = 8'(a) * 8'(b);
            item.due  = cyc + 1 + 4;
            sb_q.push_back(item);
            last_acc = cyc + 1;
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        hold_p    = 8'h00;
        last_acc  = -100;
        prev_done = 1'b0;
    endtask

    // Monitor: compare every cycle away from the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_busy = (sb_q.size() > 0) && (cyc >= sb_q[0].due - 4) && (cyc < sb_q[0].due);
            chk("busy", {7'd0, busy}, {7'd0, exp_busy});
            chk("busy_and_done", {7'd0, busy & done}, 8'h00);
            if (done) begin
                chk("done_width", {7'd0, prev_done}, 8'h00);
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("product", P, e.prod);
                    total++;
                    if (cyc != e.due) begin
                        bad++;
                        $display("FAIL latency: got cycle=%0d expected cycle=%0d", cyc, e.due);
                    end
                    hold_p = e.prod;
                end
            end else begin
                chk("p_hold", P, hold_p);
                if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
                    total++;
                    bad++;
                    $display("FAIL missing_done: got none expected done at cycle=%0d", sb_q[0].due);
                    e = sb_q.pop_front();
                end
            end
            prev_done = done;
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst_n = 1'b0;
        start = 1'b0;
        A_i   = 4'h0;
        B_i   = 4'h0;
        #17;
        chk("reset_P", P, 8'h00);
        chk("reset_busy", {7'd0, busy}, 8'h00);
        chk("reset_done", {7'd0, done}, 8'h00);
        #5;
        rst_n = 1'b1;

        // directed products, including full carry retention and zeros
        drive(1'b1, 4'd3, 4'd5);
        repeat (6) drive(1'b0, 4'h0, 4'h0);
        drive(1'b1, 4'hF, 4'hF);
        repeat (6) drive(1'b0, 4'h0, 4'h0);
        drive(1'b1, 4'h0, 4'h9);
        repeat (5) drive(1'b0, 4'h0, 4'h0);
        drive(1'b1, 4'h7, 4'h0);
        repeat (6) drive(1'b0, 4'h0, 4'h0);

        // start during CALC is ignored; start held through DONE chains
        drive(1'b1, 4'd2, 4'd6);
        drive(1'b0, 4'h0, 4'h0);
        drive(1'b1, 4'hF, 4'hF);
        repeat (3) drive(1'b1, 4'd4, 4'd4);
        drive(1'b0, 4'h0, 4'h0);
        repeat (6) drive(1'b0, 4'h0, 4'h0);

        // asynchronous reset in the middle of CALC aborts the operation
        drive(1'b1, 4'd9, 4'd9);
        drive(1'b0, 4'h0, 4'h0);
        drive(1'b0, 4'h0, 4'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_P", P, 8'h00);
        chk("abort_busy", {7'd0, busy}, 8'h00);
        chk("abort_done", {7'd0, done}, 8'h00);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (8) drive(1'b0, 4'h0, 4'h0);

        // exhaustive sweep with ignored noise starts and random idle gaps
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(1'b1, 4'(a), 4'(b));
                repeat (4) drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                                 4'($urandom_range(0, 15)));
                repeat ($urandom_range(0, 3)) drive(1'b0, 4'h0, 4'h0);
            end
        end
        repeat (8) drive(1'b0, 4'h0, 4'h0);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got pending=%0d expected pending=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
